// File: rtl/cpu_pkg.sv
// Shared core constants: default datapath width, fetch increment and the
// encodings of the 2-bit direction counter.
package cpu_pkg;
  localparam int DBITS_DEF = 16;
  localparam int PC_INC    = 2;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken
endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load. Used for the per-entry
// direction counters and for the performance counters.
module sat_counter #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  // Reset wins over load, load wins over counting; inc and dec together cancel.
  always_ff @(posedge clk) begin
    // NOTE: state is always written with <= so every flop samples the pre-edge
    // value of its inputs, regardless of block ordering.
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !dec && (count != '1)) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer for the fetch stage. Lookup is purely
// combinational from pc; training from the resolve stage lands on the next
// edge, so a same-cycle lookup of the entry being trained sees old contents.
module branch_target_predictor
  import cpu_pkg::*;
#(
  parameter int         DBITS    = DBITS_DEF,
  parameter int         IDXBITS  = 6,
  parameter bit         USE_CTR  = 1'b1,
  parameter logic [1:0] CTR_INIT = CTR_WT,
  parameter int         CNTBITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DBITS-1:0]   pc,
  output logic [DBITS-1:0]   pred_pc,
  output logic               pred_hit,
  output logic               pred_taken,
  input  logic               upd_en,
  input  logic [DBITS-1:0]   upd_pc,
  input  logic               upd_taken,
  input  logic [DBITS-1:0]   upd_target,
  input  logic               upd_mispred,
  input  logic               inv_all,
  output logic [CNTBITS-1:0] hit_cnt,
  output logic [CNTBITS-1:0] mispred_cnt
);

  localparam int ENTRIES = 2 ** IDXBITS;
  localparam int TAGBITS = DBITS - IDXBITS - 1;

  logic               valid      [ENTRIES];
  logic [TAGBITS-1:0] tag_arr    [ENTRIES];
  logic [DBITS-1:0]   target_arr [ENTRIES];
  logic [1:0]         ctr        [ENTRIES];

  logic [IDXBITS-1:0] idx, upd_idx;
  logic [TAGBITS-1:0] tag, upd_tag;
  logic               upd_hit, train, alloc, drop;
  logic               unused_lsbs;

  // Bit 0 of an instruction address is always zero on this core.
  assign unused_lsbs = pc[0] ^ upd_pc[0];

  assign idx     = pc[IDXBITS:1];
  assign tag     = pc[DBITS-1:IDXBITS+1];
  assign upd_idx = upd_pc[IDXBITS:1];
  assign upd_tag = upd_pc[DBITS-1:IDXBITS+1];

  // Lookup path: no bypass from the update port.
  assign pred_hit   = valid[idx] && (tag_arr[idx] == tag);
  assign pred_taken = pred_hit && (USE_CTR ? ctr[idx][1] : 1'b1);
  assign pred_pc    = pred_taken ? target_arr[idx] : pc + DBITS'(PC_INC);

  // Training decode; inv_all drops the coincident update entirely.
  assign upd_hit = valid[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  assign train   = upd_en && !inv_all && upd_hit;
  assign alloc   = upd_en && !inv_all && !upd_hit && upd_taken;
  assign drop    = train && !upd_taken && !USE_CTR;

  // Valid bits: cleared by reset or flash-invalidate, set on allocation.
  always_ff @(posedge clk) begin
    if (reset || inv_all) begin
      for (int e = 0; e < ENTRIES; e++) valid[e] <= 1'b0;
    end else if (alloc) begin
      valid[upd_idx] <= 1'b1;
    end else if (drop) begin
      valid[upd_idx] <= 1'b0;
    end
  end

  // Tag and target storage; only qualified by valid, so never reset.
  always_ff @(posedge clk) begin
    // NOTE: tag/target arrays are deliberately left without reset; valid gates
    // every use, and omitting the reset keeps them as plain storage.
    if (!reset && alloc) begin
      tag_arr[upd_idx] <= upd_tag;
    end
    if (!reset && (alloc || (train && upd_taken))) begin
      target_arr[upd_idx] <= upd_target;
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = (upd_idx == IDXBITS'(e));
    sat_counter #(.WIDTH(2), .RST_VAL(CTR_INIT)) u_dir_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (alloc && sel),
      .load_val (CTR_INIT),
      .inc      (train && upd_taken && sel),
      .dec      (train && !upd_taken && sel),
      .count    (ctr[e])
    );
  end

  sat_counter #(.WIDTH(CNTBITS), .RST_VAL('0)) u_hit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (pred_hit),
    .dec      (1'b0),
    .count    (hit_cnt)
  );

  sat_counter #(.WIDTH(CNTBITS), .RST_VAL('0)) u_mispred_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (upd_en && upd_mispred),
    .dec      (1'b0),
    .count    (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: one instance with direction counters and
// 16-bit performance counters, one without counters and 4-bit performance
// counters (so counter saturation is reachable). Both share stimulus and each
// has its own behavioural model.
module tb_branch_target_predictor;
  localparam int NE = 64;

  logic        clk = 1'b0;
  logic        reset, upd_en, upd_taken, upd_mispred, inv_all;
  logic [15:0] pc, upd_pc, upd_target;
  logic [15:0] pred_pc [2];
  logic        pred_hit [2];
  logic        pred_taken [2];
  logic [15:0] hit_cnt0, mispred_cnt0;
  logic [3:0]  hit_cnt1, mispred_cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_target_predictor u_ctr (
    .clk(clk), .reset(reset), .pc(pc), .pred_pc(pred_pc[0]), .pred_hit(pred_hit[0]),
    .pred_taken(pred_taken[0]), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .inv_all(inv_all),
    .hit_cnt(hit_cnt0), .mispred_cnt(mispred_cnt0)
  );

  branch_target_predictor #(.USE_CTR(1'b0), .CNTBITS(4)) u_noctr (
    .clk(clk), .reset(reset), .pc(pc), .pred_pc(pred_pc[1]), .pred_hit(pred_hit[1]),
    .pred_taken(pred_taken[1]), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .inv_all(inv_all),
    .hit_cnt(hit_cnt1), .mispred_cnt(mispred_cnt1)
  );

  // ---------------- behavioural model ----------------
  bit          m_valid [2][NE];
  int          m_tag   [2][NE];
  logic [15:0] m_tgt   [2][NE];
  int          m_ctr   [2][NE];
  int          m_hc [2];
  int          m_mc [2];

  function automatic int cnt_max(input int m);
    return (m == 0) ? 65535 : 15;
  endfunction

  function automatic int idx_of(input logic [15:0] a);
    return (int'(a) / 2) % NE;
  endfunction

  function automatic int tag_of(input logic [15:0] a);
    return int'(a) / (2 * NE);
  endfunction

  task automatic model_lookup(input int m, input logic [15:0] a,
                              output bit hit, output bit tk, output logic [15:0] npc);
    int i = idx_of(a);
    hit = m_valid[m][i] && (m_tag[m][i] == tag_of(a));
    tk  = hit && ((m == 1) || (m_ctr[m][i] >= 2));
    npc = tk ? m_tgt[m][i] : 16'((int'(a) + 2) % 65536);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[m][i] = 1'b0;
        m_ctr[m][i]   = 2;
      end
      m_hc[m] = 0;
      m_mc[m] = 0;
    end
  endtask

  // Apply one clock edge of the architectural rules to the model.
  task automatic model_step();
    bit hit, tk;
    logic [15:0] npc;
    int i;
    if (reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      model_lookup(m, pc, hit, tk, npc);
      if (hit && m_hc[m] < cnt_max(m)) m_hc[m]++;
      if (upd_en && upd_mispred && m_mc[m] < cnt_max(m)) m_mc[m]++;
      if (inv_all) begin
        for (int e = 0; e < NE; e++) m_valid[m][e] = 1'b0;
      end else if (upd_en) begin
        i = idx_of(upd_pc);
        if (m_valid[m][i] && m_tag[m][i] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            if (m_ctr[m][i] < 3) m_ctr[m][i]++;
            m_tgt[m][i] = upd_target;
          end else begin
            if (m_ctr[m][i] > 0) m_ctr[m][i]--;
            if (m == 1) m_valid[m][i] = 1'b0;
          end
        end else if (upd_taken) begin
          m_valid[m][i] = 1'b1;
          m_tag[m][i]   = tag_of(upd_pc);
          m_tgt[m][i]   = upd_target;
          m_ctr[m][i]   = 2;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directed expectation on one instance.
  task automatic dchk(input int m, input string name, input bit hit, input logic [15:0] npc);
    check($sformatf("%s.u%0d.hit", name, m), 32'(pred_hit[m]), 32'(hit));
    check($sformatf("%s.u%0d.pred_pc", name, m), 32'(pred_pc[m]), 32'(npc));
  endtask

  // Inputs are already set (just after a falling edge): compare, clock, model.
  task automatic cycle();
    bit hit, tk;
    logic [15:0] npc;
    #1;
    for (int m = 0; m < 2; m++) begin
      model_lookup(m, pc, hit, tk, npc);
      check($sformatf("m.u%0d.hit", m), 32'(pred_hit[m]), 32'(hit));
      check($sformatf("m.u%0d.taken", m), 32'(pred_taken[m]), 32'(tk));
      check($sformatf("m.u%0d.pred_pc", m), 32'(pred_pc[m]), 32'(npc));
      check($sformatf("m.u%0d.hit_cnt", m),
            (m == 0) ? 32'(hit_cnt0) : 32'(hit_cnt1), 32'(m_hc[m]));
      check($sformatf("m.u%0d.mispred_cnt", m),
            (m == 0) ? 32'(mispred_cnt0) : 32'(mispred_cnt1), 32'(m_mc[m]));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; upd_en = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0; inv_all = 1'b0;
  endtask

  task automatic upd(input logic [15:0] a, input bit tk, input logic [15:0] tgt, input bit mis);
    upd_en = 1'b1; upd_pc = a; upd_taken = tk; upd_target = tgt; upd_mispred = mis;
  endtask

  logic [15:0] pool [16];

  initial begin
    idle();
    upd_pc = '0; upd_target = '0;
    pc = 16'h0200;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    #1;
    dchk(0, "reset", 1'b0, 16'h0202);
    check("reset.hit_cnt", 32'(hit_cnt0), 32'd0);
    check("reset.mispred_cnt", 32'(mispred_cnt0), 32'd0);
    cycle();

    // Allocate 0x0210 -> 0x0240 with a mispredict
    idle(); upd(16'h0210, 1'b1, 16'h0240, 1'b1); cycle();
    idle(); pc = 16'h0210; #1;
    dchk(0, "alloc", 1'b1, 16'h0240);
    check("alloc.taken", 32'(pred_taken[0]), 32'd1);
    check("alloc.mispred_cnt", 32'(mispred_cnt0), 32'd1);
    cycle();

    // Hysteresis: 10 -> 01 (not taken), counter-less instance drops the entry
    upd(16'h0210, 1'b0, 16'h0240, 1'b0); cycle();
    idle(); #1;
    dchk(0, "hyst.nt", 1'b1, 16'h0212);
    dchk(1, "noctr.inval", 1'b0, 16'h0212);
    cycle();
    repeat (2) begin upd(16'h0210, 1'b1, 16'h0240, 1'b0); cycle(); end  // 01 -> 11
    upd(16'h0210, 1'b0, 16'h0240, 1'b0); cycle();                      // 11 -> 10
    idle(); #1; dchk(0, "hyst.strong", 1'b1, 16'h0240); cycle();
    repeat (3) begin upd(16'h0210, 1'b1, 16'h0240, 1'b0); cycle(); end  // saturates at 11
    upd(16'h0210, 1'b0, 16'h0240, 1'b0); cycle();                      // 11 -> 10
    idle(); #1; dchk(0, "hyst.sat", 1'b1, 16'h0240); cycle();
    upd(16'h0210, 1'b0, 16'h0240, 1'b0); cycle();                      // 10 -> 01
    idle(); #1; dchk(0, "hyst.down", 1'b1, 16'h0212); cycle();

    // Aliasing on index 8
    upd(16'h0290, 1'b1, 16'h0500, 1'b0); cycle();
    idle(); pc = 16'h0210; #1; dchk(0, "alias.old", 1'b0, 16'h0212); cycle();
    pc = 16'h0290; #1; dchk(0, "alias.new", 1'b1, 16'h0500); cycle();

    // Same-cycle lookup and allocation: no bypass
    pc = 16'h0300; upd(16'h0300, 1'b1, 16'h0124, 1'b0); #1;
    dchk(0, "same.cycle", 1'b0, 16'h0302); cycle();
    idle(); #1; dchk(0, "same.next", 1'b1, 16'h0124); cycle();

    // inv_all beats the coincident update and clears everything
    pc = 16'h0400; upd(16'h0400, 1'b1, 16'h0440, 1'b0); inv_all = 1'b1; cycle();
    idle(); #1; dchk(0, "inv.drop", 1'b0, 16'h0402); cycle();
    pc = 16'h0300; #1; dchk(0, "inv.clear", 1'b0, 16'h0302); cycle();

    // Counter-less instance: hit then not-taken invalidates
    upd(16'h0600, 1'b1, 16'h0660, 1'b0); cycle();
    idle(); pc = 16'h0600; #1; dchk(1, "noctr.hit", 1'b1, 16'h0660); cycle();
    upd(16'h0600, 1'b0, 16'h0660, 1'b0); cycle();
    idle(); #1; dchk(1, "noctr.nt", 1'b0, 16'h0602); cycle();

    // Fall-through wrap
    pc = 16'hFFFE; #1;
    dchk(0, "wrap", 1'b0, 16'h0000);
    dchk(1, "wrap", 1'b0, 16'h0000);
    cycle();

    // Reset mid-training discards the update
    upd(16'h0800, 1'b1, 16'h0880, 1'b1); reset = 1'b1; cycle();
    idle(); pc = 16'h0800; #1;
    dchk(0, "rst.upd", 1'b0, 16'h0802);
    check("rst.upd.mispred_cnt", 32'(mispred_cnt0), 32'd0);
    cycle();

    // Randomised traffic over a small aliasing address pool
    for (int i = 0; i < 16; i++) pool[i] = 16'((i % 4) * 2 + (i / 4) * 128);
    pool[15] = 16'hFFFE;
    for (int n = 0; n < 600; n++) begin
      idle();
      pc          = pool[$urandom_range(15)];
      upd_en      = ($urandom_range(1) == 1);
      upd_pc      = pool[$urandom_range(15)];
      upd_taken   = ($urandom_range(2) != 0);
      upd_target  = 16'($urandom) & 16'hFFFE;
      upd_mispred = ($urandom_range(3) == 0);
      inv_all     = ($urandom_range(63) == 0);
      reset       = ($urandom_range(199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised fetch-stage predictor that replaces the flat next-PC table of the pipelined 16-bit core.
- Holds a direct-mapped branch target buffer: valid bit, tag, target and an optional 2-bit saturating direction counter per entry.
- Gives a next-PC prediction in the same cycle as PC is presented.
- Is trained from the resolve stage when a branch or jump completes, and keeps hit and mispredict performance counters.

Parameters:
- DBITS, 16, width of PC and target.
- IDXBITS, 6, index width; ENTRIES = 2**IDXBITS.
- USE_CTR, 1, 1 = 2-bit counter direction prediction; 0 = hit always predicts taken.
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken).
- CNTBITS, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  DBITS  current fetch PC (2-byte aligned).
- pred_pc  out  DBITS  predicted next PC.
- pred_hit  out  1  valid tag match at pc.
- pred_taken  out  1  prediction uses the stored target.
- upd_en  in  1  a resolved control-flow instruction is training the table this cycle.
- upd_pc  in  DBITS  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  DBITS  actual target.
- upd_mispred  in  1  pipeline flushed for this instruction; only meaningful with upd_en.
- inv_all  in  1  invalidate every entry.
- hit_cnt  out  CNTBITS  number of lookups that hit.
- mispred_cnt  out  CNTBITS  number of updates with upd_mispred set.

Behaviour:
- Addressing:
  - idx = pc[IDXBITS:1]; tag = pc[DBITS-1:IDXBITS+1]; bit 0 is ignored.
  - The same split applies to upd_pc.
- Lookup (combinational from pc and current state; zero latency):
  - pred_hit = valid[idx] && tag_arr[idx] == tag.
  - pred_taken = pred_hit && (USE_CTR ? ctr[idx][1] : 1).
  - pred_pc = pred_taken ? target[idx] : pc + 2, truncated to DBITS; wrap-around at 0xFFFE gives 0x0000.
- Update (registered; visible to lookup from the next cycle):
  - If lookup and update address the same entry in one cycle, the lookup sees the old contents. There is no bypass.
  - upd_en and tag hit:
    - Counter +1 if taken, −1 if not, saturating at 2'b11 and 2'b00.
    - Target is written only when taken.
  - upd_en, miss, taken: allocate and overwrite the entry. valid=1, tag, target=upd_target, ctr=CTR_INIT.
  - upd_en, miss, not taken: no table change.
  - USE_CTR=0, hit, not taken: clear valid for that entry.
- Priority at each edge: reset > inv_all > upd_en.
  - inv_all clears all valid bits in one cycle; the coincident update is dropped.
  - Counters and targets are left unchanged by inv_all.
- Performance counters:
  - hit_cnt increments on every cycle with pred_hit=1 and reset=0.
  - mispred_cnt increments on upd_en && upd_mispred.
  - Both saturate at all-ones; neither is cleared by inv_all.
- Reset:
  - All valid=0, all ctr=CTR_INIT, hit_cnt=0, mispred_cnt=0. Targets and tags are don't-care.
  - Outputs during and after reset are therefore pred_hit=0, pred_taken=0, pred_pc=pc+2.
  - Reset asserted mid-training discards that cycle's update.
- No internal FSM. State is ENTRIES×(1+TAGBITS+DBITS+2) flops plus two counters. The table is register-based so the read stays asynchronous.

Decomposition:
- Shared package (cpu_pkg): DBITS default, PC increment constant 2, counter encodings CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
- Sub-module sat_counter (parametrised width, inc/dec/load, saturating). It is instantiated for the per-entry direction counters and the two performance counters.

Test Plan:
- Reset with pc=0x0200: pred_hit=0, pred_pc=0x0202, hit_cnt=0, mispred_cnt=0.
- Allocate: upd_en, upd_pc=0x0210, taken, target=0x0240, mispred=1. Next cycle pc=0x0210 gives pred_hit=1, pred_taken=1, pred_pc=0x0240, and mispred_cnt=1.
- Hysteresis (USE_CTR=1), continuing from allocate (ctr=10):
  - One not-taken update on 0x0210 gives ctr=01, pred_pc=0x0212.
  - Two taken updates give ctr=11.
  - Three further taken updates leave ctr=11 (saturates).
- Aliasing (IDXBITS=6): allocate 0x0210 then 0x0290, which share idx 8 with a different tag. pc=0x0210 misses (pred_pc=0x0212); pc=0x0290 hits.
- Same-cycle update/lookup: pc=upd_pc=0x0300 while allocating. pred_hit=0 in that cycle and 1 in the next. With inv_all and upd_en together, the entry stays invalid.
- USE_CTR=0: a not-taken update on a hitting entry invalidates it. Separately, pc=0xFFFE on a miss gives pred_pc=0x0000.
